// File: rtl/ahbl_splitter_if.sv
// Bus bundle for the 1:N AHB-Lite splitter: upstream (ahbls_*) and per-port downstream (ahblm_*) signals.
// The splitter connects to the slave modport; the environment connects to the master modport.
interface ahbl_splitter_if #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned W_ADDR  = 32,
  parameter int unsigned W_DATA  = 32
);
  logic                        ahbls_hready;
  logic                        ahbls_hready_resp;
  logic                        ahbls_hresp;
  logic [W_ADDR-1:0]           ahbls_haddr;
  logic                        ahbls_hwrite;
  logic [1:0]                  ahbls_htrans;
  logic [2:0]                  ahbls_hsize;
  logic [2:0]                  ahbls_hburst;
  logic [3:0]                  ahbls_hprot;
  logic                        ahbls_hmastlock;
  logic [W_DATA-1:0]           ahbls_hwdata;
  logic [W_DATA-1:0]           ahbls_hrdata;

  logic [N_PORTS-1:0]          ahblm_hready;
  logic [N_PORTS-1:0]          ahblm_hready_resp;
  logic [N_PORTS-1:0]          ahblm_hresp;
  logic [N_PORTS*W_ADDR-1:0]   ahblm_haddr;
  logic [N_PORTS-1:0]          ahblm_hwrite;
  logic [N_PORTS*2-1:0]        ahblm_htrans;
  logic [N_PORTS*3-1:0]        ahblm_hsize;
  logic [N_PORTS*3-1:0]        ahblm_hburst;
  logic [N_PORTS*4-1:0]        ahblm_hprot;
  logic [N_PORTS-1:0]          ahblm_hmastlock;
  logic [N_PORTS*W_DATA-1:0]   ahblm_hwdata;
  logic [N_PORTS*W_DATA-1:0]   ahblm_hrdata;

  modport slave (
    input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
           ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
    output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    output ahblm_hready, ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize,
           ahblm_hburst, ahblm_hprot, ahblm_hmastlock, ahblm_hwdata,
    input  ahblm_hready_resp, ahblm_hresp, ahblm_hrdata
  );

  modport master (
    output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
           ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
    input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    input  ahblm_hready, ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize,
           ahblm_hburst, ahblm_hprot, ahblm_hmastlock, ahblm_hwdata,
    output ahblm_hready_resp, ahblm_hresp, ahblm_hrdata
  );
endinterface

// File: rtl/ahbl_splitter.sv
// 1:N AHB-Lite address decoder and response mux with an internal default slave
// that answers unmapped transfers with a two-cycle ERROR response.
module ahbl_splitter #(
  parameter int unsigned               N_PORTS   = 2,
  parameter int unsigned               W_ADDR    = 32,
  parameter int unsigned               W_DATA    = 32,
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MAP  = '0,
  parameter logic [N_PORTS*W_ADDR-1:0] ADDR_MASK = '0
) (
  input logic            clk,
  input logic            rst,
  ahbl_splitter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ERR1, ST_ERR2} state_t;

  state_t             state, state_nxt;
  logic [N_PORTS-1:0] sel_a;
  logic [N_PORTS:0]   sel_d;
  logic               found;
  logic               active;
  logic               unmapped;

  // Lowest-index match wins when address windows overlap.
  always_comb begin
    sel_a = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (!found &&
          ((bus.ahbls_haddr & ADDR_MASK[i*W_ADDR +: W_ADDR]) == ADDR_MAP[i*W_ADDR +: W_ADDR])) begin
        sel_a[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign active   = bus.ahbls_htrans[1];
  assign unmapped = active && !found;

  assign bus.ahblm_hready    = {N_PORTS{bus.ahbls_hready}};
  assign bus.ahblm_haddr     = {N_PORTS{bus.ahbls_haddr}};
  assign bus.ahblm_hwrite    = {N_PORTS{bus.ahbls_hwrite}};
  assign bus.ahblm_hsize     = {N_PORTS{bus.ahbls_hsize}};
  assign bus.ahblm_hburst    = {N_PORTS{bus.ahbls_hburst}};
  assign bus.ahblm_hprot     = {N_PORTS{bus.ahbls_hprot}};
  assign bus.ahblm_hmastlock = {N_PORTS{bus.ahbls_hmastlock}};
  assign bus.ahblm_hwdata    = {N_PORTS{bus.ahbls_hwdata}};

  // Reset also masks htrans so no slave sees an active transfer while held in reset.
  always_comb begin
    bus.ahblm_htrans = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      if (sel_a[i] && !rst) bus.ahblm_htrans[i*2 +: 2] = bus.ahbls_htrans;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_d <= '0;
    end else if (bus.ahbls_hready) begin
      if (unmapped)    sel_d <= {1'b1, {N_PORTS{1'b0}}};
      else if (active) sel_d <= {1'b0, sel_a};
      else             sel_d <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.ahbls_hready && unmapped) state_nxt = ST_ERR1;
      ST_ERR1: state_nxt = ST_ERR2;
      ST_ERR2: state_nxt = (bus.ahbls_hready && unmapped) ? ST_ERR1 : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ahbls_hready_resp = 1'b1;
    bus.ahbls_hresp       = 1'b0;
    bus.ahbls_hrdata      = '0;
    case (state)
      ST_ERR1: begin
        bus.ahbls_hready_resp = 1'b0;
        bus.ahbls_hresp       = 1'b1;
      end
      ST_ERR2: begin
        bus.ahbls_hready_resp = 1'b1;
        bus.ahbls_hresp       = 1'b1;
      end
      default: begin
        if (!sel_d[N_PORTS]) begin
          for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (sel_d[i]) begin
              bus.ahbls_hready_resp = bus.ahblm_hready_resp[i];
              bus.ahbls_hresp       = bus.ahblm_hresp[i];
              bus.ahbls_hrdata      = bus.ahblm_hrdata[i*W_DATA +: W_DATA];
            end
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_ahbl_splitter.sv
// Directed and randomized checks of ahbl_splitter against a transaction-level reference model.
module tb_ahbl_splitter;
  localparam int N = 3;
  localparam logic [N*32-1:0] MAP   = {32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
  localparam logic [N*32-1:0] MASK  = {32'hC000_0000, 32'hF000_0000, 32'hF000_0000};
  localparam logic [N*32-1:0] MAP2  = {32'h8000_0000, 32'h4000_0000, 32'h4000_0000};
  localparam logic [N*32-1:0] MASK2 = {32'hC000_0000, 32'hF000_0000, 32'hC000_0000};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahbl_splitter_if #(.N_PORTS(N), .W_ADDR(32), .W_DATA(32)) bus ();
  ahbl_splitter_if #(.N_PORTS(N), .W_ADDR(32), .W_DATA(32)) bus2 ();

  ahbl_splitter #(.N_PORTS(N), .W_ADDR(32), .W_DATA(32), .ADDR_MAP(MAP), .ADDR_MASK(MASK))
    dut (.clk(clk), .rst(rst), .bus(bus));
  ahbl_splitter #(.N_PORTS(N), .W_ADDR(32), .W_DATA(32), .ADDR_MAP(MAP2), .ADDR_MASK(MASK2))
    dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Stimulus for the main DUT
  logic        m_hready;
  logic [31:0] m_addr;
  logic        m_write;
  logic [1:0]  m_trans;
  logic [31:0] m_wdata;
  logic        s_ready [N];
  logic        s_resp  [N];
  logic [31:0] s_rdata [N];

  assign bus.ahbls_hready    = m_hready;
  assign bus.ahbls_haddr     = m_addr;
  assign bus.ahbls_hwrite    = m_write;
  assign bus.ahbls_htrans    = m_trans;
  assign bus.ahbls_hsize     = 3'b010;
  assign bus.ahbls_hburst    = 3'b000;
  assign bus.ahbls_hprot     = 4'b0011;
  assign bus.ahbls_hmastlock = 1'b0;
  assign bus.ahbls_hwdata    = m_wdata;
  for (genvar g = 0; g < N; g++) begin : g_sl
    assign bus.ahblm_hready_resp[g]    = s_ready[g];
    assign bus.ahblm_hresp[g]          = s_resp[g];
    assign bus.ahblm_hrdata[g*32 +: 32] = s_rdata[g];
  end

  // Overlapping-window DUT: static NONSEQ access to 0x40000000
  assign bus2.ahbls_hready      = 1'b1;
  assign bus2.ahbls_haddr       = 32'h4000_0000;
  assign bus2.ahbls_hwrite      = 1'b0;
  assign bus2.ahbls_htrans      = 2'b10;
  assign bus2.ahbls_hsize       = 3'b010;
  assign bus2.ahbls_hburst      = 3'b000;
  assign bus2.ahbls_hprot       = 4'b0011;
  assign bus2.ahbls_hmastlock   = 1'b0;
  assign bus2.ahbls_hwdata      = 32'h0;
  assign bus2.ahblm_hready_resp = '1;
  assign bus2.ahblm_hresp       = '0;
  assign bus2.ahblm_hrdata      = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  // Reference model: address windows per port, data-phase owner and error-response phase
  logic [31:0] map_a  [N] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000};
  logic [31:0] mask_a [N] = '{32'hF000_0000, 32'hF000_0000, 32'hC000_0000};
  int m_dp  = -1;  // -1 none, 0..N-1 port, N default slave
  int m_err = 0;   // 0 none, 1 first error cycle, 2 second error cycle
  int total = 0;
  int bad   = 0;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < N; i++) if ((a & mask_a[i]) == map_a[i]) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_dp  = -1;
    m_err = 0;
  endtask

  // One bus cycle: drive hready from the model, compare, clock, advance the model.
  task automatic step(input string tag);
    logic           er, ep;
    logic [31:0]    ed;
    logic [2*N-1:0] eh;
    int             p, nerr;
    if (m_err == 1)                begin er = 1'b0; ep = 1'b1; ed = '0; end
    else if (m_err == 2)           begin er = 1'b1; ep = 1'b1; ed = '0; end
    else if (m_dp >= 0 && m_dp < N) begin er = s_ready[m_dp]; ep = s_resp[m_dp]; ed = s_rdata[m_dp]; end
    else                           begin er = 1'b1; ep = 1'b0; ed = '0; end
    m_hready = er;
    p  = decode(m_addr);
    eh = '0;
    if (p >= 0 && !rst) eh[2*p +: 2] = m_trans;
    #1;
    check({tag, ".hready_resp"}, 64'(bus.ahbls_hready_resp), 64'(er));
    check({tag, ".hresp"},       64'(bus.ahbls_hresp),       64'(ep));
    check({tag, ".hrdata"},      64'(bus.ahbls_hrdata),      64'(ed));
    check({tag, ".htrans"},      64'(bus.ahblm_htrans),      64'(eh));
    check({tag, ".m_hready"},    64'(bus.ahblm_hready),      64'({N{er}}));
    check({tag, ".m_haddr2"},    64'(bus.ahblm_haddr[95:64]), 64'(m_addr));
    check({tag, ".m_hwdata1"},   64'(bus.ahblm_hwdata[63:32]), 64'(m_wdata));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      nerr = (m_err == 1) ? 2 : ((er && m_trans[1] && p < 0) ? 1 : 0);
      if (er) m_dp = m_trans[1] ? ((p < 0) ? N : p) : -1;
      m_err = nerr;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; m_hready = 1'b1; m_addr = '0; m_write = 1'b0; m_trans = 2'b00; m_wdata = 32'h0;
    for (int i = 0; i < N; i++) begin s_ready[i] = 1'b1; s_resp[i] = 1'b0; s_rdata[i] = '0; end
    #1;
    check("rst.hready_resp", 64'(bus.ahbls_hready_resp), 64'd1);
    check("rst.hresp",       64'(bus.ahbls_hresp),       64'd0);
    check("rst.hrdata",      64'(bus.ahbls_hrdata),      64'd0);
    check("rst.dut2_htrans", 64'(bus2.ahblm_htrans),     64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("ovl.htrans", 64'(bus2.ahblm_htrans), 64'b00_00_10);

    // Mapped read to port1
    m_addr = 32'h4000_0010; m_trans = 2'b10; s_rdata[1] = 32'hCAFE_F00D;
    #1 check("t1.htrans", 64'(bus.ahblm_htrans), 64'b00_10_00);
    step("t1a");
    check("ovl.hrdata", 64'(bus2.ahbls_hrdata), 64'h1111_1111);
    m_trans = 2'b00;
    #1 check("t1.rdata", 64'(bus.ahbls_hrdata), 64'hCAFE_F00D);
    step("t1d");

    // Port0 with two wait states, port2 address held during the stall
    m_addr = 32'h0000_0004; m_trans = 2'b10;
    step("t2a");
    m_addr = 32'h8000_0000; s_ready[0] = 1'b0;
    #1 check("t2.w1_ready", 64'(bus.ahbls_hready_resp), 64'd0);
    check("t2.w1_htrans", 64'(bus.ahblm_htrans), 64'b10_00_00);
    step("t2w1");
    #1 check("t2.w2_ready", 64'(bus.ahbls_hready_resp), 64'd0);
    step("t2w2");
    s_ready[0] = 1'b1; s_rdata[0] = 32'h1234_5678;
    #1 check("t2.p0_rdata", 64'(bus.ahbls_hrdata), 64'h1234_5678);
    step("t2d0");
    m_trans = 2'b00; s_rdata[2] = 32'hA5A5_0002;
    #1 check("t2.p2_rdata", 64'(bus.ahbls_hrdata), 64'hA5A5_0002);
    step("t2d2");

    // Unmapped write, then cancel during ERR2
    m_addr = 32'h2000_0000; m_write = 1'b1; m_trans = 2'b10; m_wdata = 32'hDEAD_BEEF;
    #1 check("t3.htrans", 64'(bus.ahblm_htrans), 64'd0);
    step("t3a");
    m_trans = 2'b00; m_write = 1'b0;
    #1 check("t3.err1", 64'({bus.ahbls_hready_resp, bus.ahbls_hresp}), 64'b01);
    step("t3e1");
    #1 check("t3.err2", 64'({bus.ahbls_hready_resp, bus.ahbls_hresp}), 64'b11);
    step("t3e2");
    #1 check("t3.idle", 64'({bus.ahbls_hready_resp, bus.ahbls_hresp}), 64'b10);
    step("t3i");

    // Two consecutive unmapped transfers
    m_addr = 32'h2000_0000; m_trans = 2'b10;
    step("t4a");
    m_addr = 32'h3000_0000;
    #1 check("t4.err1a", 64'({bus.ahbls_hready_resp, bus.ahbls_hresp}), 64'b01);
    step("t4e1a");
    #1 check("t4.err2a", 64'({bus.ahbls_hready_resp, bus.ahbls_hresp}), 64'b11);
    step("t4e2a");
    m_trans = 2'b00;
    #1 check("t4.err1b", 64'({bus.ahbls_hready_resp, bus.ahbls_hresp}), 64'b01);
    step("t4e1b");
    step("t4e2b");
    step("t4i");

    // BUSY is forwarded but loads no data phase
    m_addr = 32'h4000_0040; m_trans = 2'b01; s_rdata[1] = 32'h0BAD_0BAD;
    step("busy");
    m_trans = 2'b00;
    step("busy_d");

    // Reset during port1 wait state
    m_addr = 32'h4000_0020; m_trans = 2'b10;
    step("r1a");
    m_addr = 32'h4000_0030; s_ready[1] = 1'b0;
    #1 check("r1.wait", 64'(bus.ahbls_hready_resp), 64'd0);
    rst = 1'b1; model_reset();
    #1 check("r1.out", 64'({bus.ahbls_hready_resp, bus.ahbls_hresp, bus.ahbls_hrdata}), 64'h2_0000_0000);
    check("r1.htrans", 64'(bus.ahblm_htrans), 64'd0);
    step("r1hold");
    rst = 1'b0; s_ready[1] = 1'b1; s_rdata[1] = 32'hCAFE_0001;
    step("r1post");
    m_trans = 2'b00;
    #1 check("r1.rdata", 64'(bus.ahbls_hrdata), 64'hCAFE_0001);
    step("r1d");

    // Reset during ERR1
    m_addr = 32'h2000_0000; m_trans = 2'b10;
    step("r2a");
    m_trans = 2'b00;
    #1 check("r2.err1", 64'({bus.ahbls_hready_resp, bus.ahbls_hresp}), 64'b01);
    rst = 1'b1; model_reset();
    #1 check("r2.out", 64'({bus.ahbls_hready_resp, bus.ahbls_hresp}), 64'b10);
    step("r2hold");
    rst = 1'b0; m_addr = 32'h0000_0008; m_trans = 2'b10; s_rdata[0] = 32'h0000_5A5A;
    step("r2post");
    m_trans = 2'b00;
    step("r2d");

    // Randomized traffic with random slave wait states and responses
    for (int k = 0; k < 400; k++) begin
      if (m_hready) begin
        case ($urandom_range(0, 4))
          0:       m_addr = $urandom & 32'h0FFF_FFFF;
          1:       m_addr = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFF);
          2:       m_addr = 32'h8000_0000 | ($urandom & 32'h3FFF_FFFF);
          3:       m_addr = 32'h2000_0000 | ($urandom & 32'h1FFF_FFFF);
          default: m_addr = $urandom;
        endcase
        m_trans = 2'($urandom_range(0, 3));
        m_write = 1'($urandom);
        m_wdata = $urandom;
      end
      for (int i = 0; i < N; i++) begin
        s_ready[i] = ($urandom_range(0, 3) != 0);
        s_resp[i]  = ($urandom_range(0, 7) == 0);
        s_rdata[i] = $urandom;
      end
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
